// File: rtl/fp_pkg.sv
// Shared types for the flip/patch RAM controller: FSM states and access classes.
package fp_pkg;
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
   typedef enum logic [1:0] {CLEAN, FLIP, PATCH} cls_e;
   localparam int STAT_W = 32;
endpackage

// File: rtl/patch_table.sv
// Spare-word store for patched addresses: tag lookup, in-place update, lowest-free allocation.
module patch_table #(
   parameter int ENTRIES = 16,
   parameter int ADDR_W  = 20,
   parameter int DATA_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] tag,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   output logic              hit,
   output logic [DATA_W-1:0] hit_data,
   output logic              full
);
   localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

   logic [ENTRIES-1:0] valid;
   logic [ADDR_W-1:0]  tags [ENTRIES];
   logic [DATA_W-1:0]  data [ENTRIES];
   logic [IDX_W-1:0]   hit_idx;
   logic [IDX_W-1:0]   free_idx;

   always_comb begin
      hit      = 1'b0;
      hit_idx  = '0;
      free_idx = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (valid[i] && tags[i] == tag && !hit) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(i);
         end
      end
      // descending scan so the lowest free index wins
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (!valid[i]) free_idx = IDX_W'(i);
      end
      hit_data = hit ? data[hit_idx] : '0;
      full     = &valid;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= '0;
      end else if (wr_en && !hit && !full) begin
         valid[free_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         if (hit) begin
            data[hit_idx] <= wr_data;
         end else if (!full) begin
            tags[free_idx] <= tag;
            data[free_idx] <= wr_data;
         end
      end
   end
endmodule

// File: rtl/flip_patch_ctrl.sv
// RAM front-end that half-swaps data for flip-class words and redirects patch-class words
// to spare storage. Define FP_STATS_EN to add saturating per-class access counters.
module flip_patch_ctrl
   import fp_pkg::*;
#(
   parameter int N_WORDS       = 1 << 20,
   parameter int DATA_W        = 16,
   parameter int ADDR_W        = $clog2(N_WORDS),
   parameter int PATCH_ENTRIES = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [ADDR_W-1:0] map_addr,
   input  logic              map_flip,
   input  logic              map_patch,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              patch_overflow
`ifdef FP_STATS_EN
   ,
   output logic [STAT_W-1:0] stat_flip,
   output logic [STAT_W-1:0] stat_patch,
   output logic [STAT_W-1:0] stat_clean
`endif
);
   localparam int HALF = DATA_W / 2;

   state_e            state, state_nxt;
   cls_e              cls;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rd_data;
   logic              pt_wr, pt_hit, pt_full, ovf_set;
   logic [DATA_W-1:0] pt_data;

   function automatic logic [DATA_W-1:0] flip(input logic [DATA_W-1:0] x);
      return {x[HALF-1:0], x[DATA_W-1:HALF]};
   endfunction

   always_comb begin
      cls = CLEAN;
      if (map_patch)     cls = PATCH;
      else if (map_flip) cls = FLIP;
   end

   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      map_addr  = '0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      rd_data   = '0;
      pt_wr     = 1'b0;
      ovf_set   = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_nxt = ACCESS;
         end
         ACCESS: begin
            map_addr  = addr_q;
            mem_addr  = addr_q;
            state_nxt = RESP;
            case (cls)
               PATCH: begin
                  if (we_q) begin
                     if (pt_hit || !pt_full) begin
                        pt_wr = 1'b1;
                     end else begin
                        // table exhausted: store unflipped in the faulty RAM as best effort
                        mem_we    = 1'b1;
                        mem_wdata = wdata_q;
                        ovf_set   = 1'b1;
                     end
                  end else begin
                     rd_data = pt_hit ? pt_data : mem_rdata;
                  end
               end
               FLIP: begin
                  mem_we    = we_q;
                  mem_wdata = flip(wdata_q);
                  rd_data   = flip(mem_rdata);
               end
               default: begin
                  mem_we    = we_q;
                  mem_wdata = wdata_q;
                  rd_data   = mem_rdata;
               end
            endcase
         end
         RESP: begin
            rsp_valid = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         we_q           <= 1'b0;
         addr_q         <= '0;
         wdata_q        <= '0;
         rsp_rdata      <= '0;
         patch_overflow <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end
         if (state == ACCESS && !we_q) rsp_rdata <= rd_data;
         if (ovf_set) patch_overflow <= 1'b1;
      end
   end

   patch_table #(
      .ENTRIES (PATCH_ENTRIES),
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W)
   ) u_patch_table (
      .clk      (clk),
      .rst_n    (rst_n),
      .tag      (addr_q),
      .wr_en    (pt_wr),
      .wr_data  (wdata_q),
      .hit      (pt_hit),
      .hit_data (pt_data),
      .full     (pt_full)
   );

`ifdef FP_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_flip  <= '0;
         stat_patch <= '0;
         stat_clean <= '0;
      end else if (state == ACCESS) begin
         case (cls)
            FLIP:    if (stat_flip  != '1) stat_flip  <= stat_flip  + 1'b1;
            PATCH:   if (stat_patch != '1) stat_patch <= stat_patch + 1'b1;
            default: if (stat_clean != '1) stat_clean <= stat_clean + 1'b1;
         endcase
      end
   end
`endif
endmodule
